// File: rtl/ctrl_time_capture_8_if.sv
// Bus bundle for ctrl_time_capture_8: the observed counter/x inputs and the
// published frame results. The master drives counter/x, the slave (capture
// block) drives the results.
interface ctrl_time_capture_8_if #(
  parameter int CNT_W = 12
);
  logic [CNT_W-1:0] counter;
  logic             x;
  logic [CNT_W-1:0] time_1;
  logic [CNT_W-1:0] time_2;
  logic [CNT_W-1:0] time_3;
  logic [CNT_W-1:0] time_4;
  logic [CNT_W-1:0] time_5;
  logic [CNT_W-1:0] time_6;
  logic [CNT_W-1:0] time_7;
  logic [CNT_W-1:0] time_8;
  logic             value_1;
  logic             value_2;
  logic             value_3;
  logic             value_4;
  logic             value_5;
  logic             value_6;
  logic             value_7;
  logic             value_8;
  logic [3:0]       num_events;
  logic             done;
  logic             overflow;

  modport master (
    output counter, x,
    input  time_1, time_2, time_3, time_4, time_5, time_6, time_7, time_8,
    input  value_1, value_2, value_3, value_4, value_5, value_6, value_7, value_8,
    input  num_events, done, overflow
  );

  modport slave (
    input  counter, x,
    output time_1, time_2, time_3, time_4, time_5, time_6, time_7, time_8,
    output value_1, value_2, value_3, value_4, value_5, value_6, value_7, value_8,
    output num_events, done, overflow
  );
endinterface

// File: rtl/ctrl_time_capture_8.sv
// ctrl_time_capture_8: records level changes of x against the shared frame
// counter as up to 8 (time, value) pairs per frame, in the same format the
// 8-slot switching scheduler consumes. Results are double-buffered and
// published one cycle after the counter==FRAME_LEN-1 cycle with a done pulse.
//
// Optional build macro: CTRL_TIME_CAPTURE_GLITCH_FILTER_EN
//   defined   -> a change must persist 2 cycles to be accepted; the recorded
//                time is the first of the two cycles.
//   undefined -> every sampled difference from the reference level counts.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | after reset, waiting for the first counter==0
// S_CAPTURE | recording transitions into the working slots
// S_PUBLISH | one cycle: copy working slots to outputs, pulse done
module ctrl_time_capture_8 #(
  parameter int CNT_W     = 12,
  parameter int FRAME_LEN = 4000
) (
  input  logic                clk,
  input  logic                sta,
  ctrl_time_capture_8_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_PUBLISH
  } state_t;

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);

  state_t           state_q;

  // working (capture-side) registers
  logic             level_q, level_d;
  logic [3:0]       idx_q, idx_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] slot_t_q [8];
  logic [CNT_W-1:0] slot_t_d [8];
  logic [7:0]       slot_v_q, slot_v_d;
`ifdef CTRL_TIME_CAPTURE_GLITCH_FILTER_EN
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] pend_t_q, pend_t_d;
`endif

  // published (output-side) registers
  logic [CNT_W-1:0] out_t_q [8];
  logic [7:0]       out_v_q;
  logic [3:0]       num_q;
  logic             done_q;
  logic             out_ovf_q;

  logic             frame_start;
  logic             restart;
  logic             detect_en;
  logic             accept;
  logic [CNT_W-1:0] acc_t;
  logic             last_v;
  logic [CNT_W-1:0] pub_t [8];
  logic [7:0]       pub_v;

  // Working-set next state: optionally restart the frame, then apply detection.
  always_comb begin
    frame_start = (bus.counter == '0);
    // PUBLISH always hands over to a fresh working set; counter==0 anywhere
    // (also mid-capture after a counter jump) starts a new frame.
    restart     = frame_start || (state_q == S_PUBLISH);
    detect_en   = (state_q == S_CAPTURE) || frame_start;

    level_d  = restart ? 1'b0 : level_q;
    idx_d    = restart ? 4'd0 : idx_q;
    ovf_d    = restart ? 1'b0 : ovf_q;
    slot_v_d = restart ? 8'd0 : slot_v_q;
    for (int k = 0; k < 8; k++) begin
      slot_t_d[k] = restart ? '0 : slot_t_q[k];
    end

    accept = 1'b0;
    acc_t  = bus.counter;
`ifdef CTRL_TIME_CAPTURE_GLITCH_FILTER_EN
    pend_d   = restart ? 1'b0 : pend_q;
    pend_t_d = restart ? '0 : pend_t_q;
    if (detect_en) begin
      if (bus.x != level_d) begin
        if (pend_d) begin
          accept = 1'b1;
          acc_t  = pend_t_d;
          pend_d = 1'b0;
        end else if (bus.counter != FRAME_LAST) begin
          // a change first seen in the last cycle cannot be confirmed in this frame
          pend_d   = 1'b1;
          pend_t_d = bus.counter;
        end
      end else begin
        pend_d = 1'b0;
      end
    end
`else
    accept = detect_en && (bus.x != level_d);
`endif

    if (accept) begin
      level_d = bus.x;
      if (idx_d < 4'd8) begin
        slot_t_d[idx_d[2:0]] = acc_t;
        slot_v_d[idx_d[2:0]] = bus.x;
        idx_d                = idx_d + 4'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Publish image: unused slots get time 0 and hold the last valid level.
  always_comb begin
    last_v = (idx_q == 4'd0) ? 1'b0 : slot_v_q[3'(idx_q - 4'd1)];
    pub_v  = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < idx_q) begin
        pub_t[k] = slot_t_q[k];
        pub_v[k] = slot_v_q[k];
      end else begin
        pub_t[k] = '0;
        pub_v[k] = last_v;
      end
    end
  end

  // FSM with working-set update and registered, double-buffered outputs.
  always_ff @(posedge clk) begin
    if (sta) begin
      state_q   <= S_IDLE;
      level_q   <= 1'b0;
      idx_q     <= 4'd0;
      ovf_q     <= 1'b0;
      slot_v_q  <= '0;
      out_v_q   <= '0;
      num_q     <= 4'd0;
      done_q    <= 1'b0;
      out_ovf_q <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        slot_t_q[k] <= '0;
        out_t_q[k]  <= '0;
      end
`ifdef CTRL_TIME_CAPTURE_GLITCH_FILTER_EN
      pend_q   <= 1'b0;
      pend_t_q <= '0;
`endif
    end else begin
      level_q  <= level_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
      slot_v_q <= slot_v_d;
      for (int k = 0; k < 8; k++) begin
        slot_t_q[k] <= slot_t_d[k];
      end
`ifdef CTRL_TIME_CAPTURE_GLITCH_FILTER_EN
      pend_q   <= pend_d;
      pend_t_q <= pend_t_d;
`endif
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (frame_start) state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (bus.counter == FRAME_LAST) state_q <= S_PUBLISH;
        end
        S_PUBLISH: begin
          state_q   <= S_CAPTURE;
          out_v_q   <= pub_v;
          num_q     <= idx_q;
          out_ovf_q <= ovf_q;
          done_q    <= 1'b1;
          for (int k = 0; k < 8; k++) begin
            out_t_q[k] <= pub_t[k];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.time_1     = out_t_q[0];
  assign bus.time_2     = out_t_q[1];
  assign bus.time_3     = out_t_q[2];
  assign bus.time_4     = out_t_q[3];
  assign bus.time_5     = out_t_q[4];
  assign bus.time_6     = out_t_q[5];
  assign bus.time_7     = out_t_q[6];
  assign bus.time_8     = out_t_q[7];
  assign bus.value_1    = out_v_q[0];
  assign bus.value_2    = out_v_q[1];
  assign bus.value_3    = out_v_q[2];
  assign bus.value_4    = out_v_q[3];
  assign bus.value_5    = out_v_q[4];
  assign bus.value_6    = out_v_q[5];
  assign bus.value_7    = out_v_q[6];
  assign bus.value_8    = out_v_q[7];
  assign bus.num_events = num_q;
  assign bus.done       = done_q;
  assign bus.overflow   = out_ovf_q;

endmodule
